// File: rtl/ram1_bus_ctrl_pkg.sv
// Shared types and constants for the Ram1 bus controller slice.
// Latency: none (declarations only).
// Backpressure: n/a.
package ram1_bus_ctrl_pkg;

    // Default memory-mapped UART register addresses on the Ram1 bus
    localparam logic [15:0] DEF_UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] DEF_UART_STAT_ADDR = 16'hBF01;

    // Access sequencer states
    typedef enum logic [3:0] {
        IDLE,
        SR,
        SL,
        SW1,
        SW2,
        UR1,
        UR2,
        UW1,
        UW2,
        ACK
    } state_e;

    // Decoded destination of a MEM-stage access
    typedef enum logic [1:0] {
        TGT_SRAM,
        TGT_UDATA,
        TGT_USTAT
    } target_e;

endpackage

// File: rtl/ram1_bus_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline and the Ram1 controller.
// Latency: none (wires only).
// Backpressure: the pipeline holds request fields stable while Stall is high.
// Ports: MemRead2/MemWrite2/Addr2/DataIn2 from pipeline; DataOut2/Ack2/Stall back to it.
interface ram1_bus_ctrl_if;
    logic        MemRead2;
    logic        MemWrite2;
    logic [15:0] Addr2;
    logic [15:0] DataIn2;
    logic [15:0] DataOut2;
    logic        Ack2;
    logic        Stall;

    // Pipeline side issues requests
    modport master (
        output MemRead2, MemWrite2, Addr2, DataIn2,
        input  DataOut2, Ack2, Stall
    );

    // Controller side serves them
    modport slave (
        input  MemRead2, MemWrite2, Addr2, DataIn2,
        output DataOut2, Ack2, Stall
    );
endinterface

// File: rtl/ram1_bus_ctrl_addr_decode.sv
// Maps a 16-bit MEM-stage address onto SRAM, UART data or UART status.
// Latency: combinational.
// Backpressure: none.
// Ports: addr_i (access address), target_o (decoded destination).
module ram1_addr_decode
    import ram1_bus_ctrl_pkg::*;
#(
    parameter logic [15:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
    parameter logic [15:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR
) (
    input  logic [15:0] addr_i,
    output target_e     target_o
);

    always_comb begin
        target_o = TGT_SRAM;
        if (addr_i == UART_DATA_ADDR) begin
            target_o = TGT_UDATA;
        end else if (addr_i == UART_STAT_ADDR) begin
            target_o = TGT_USTAT;
        end
    end

endmodule

// File: rtl/ram1_bus_ctrl.sv
// Sequences MEM-stage loads/stores over the shared Ram1 bus (data SRAM + UART).
// Latency: 3 cycles accept-to-Ack2 for SRAM/UART data, 1 cycle for UART status.
// Backpressure: Stall = Req & ~Ack2 holds the pipeline until the access completes.
// Ports: Clk/Rst (async active-low); bus (pipeline request/response bundle);
//        Ram1_EN/OE/WE, Ram1_address, Ram1_data (SRAM side); rdn/wrn,
//        data_ready/tbre/tsre (UART side).
module ram1_bus_ctrl
    import ram1_bus_ctrl_pkg::*;
#(
    parameter logic [15:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
    parameter logic [15:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR
) (
    input  logic               Clk,
    input  logic               Rst,
    ram1_bus_ctrl_if.slave     bus,
    output logic               Ram1_EN,
    output logic               Ram1_OE,
    output logic               Ram1_WE,
    output logic [17:0]        Ram1_address,
    inout  wire  [15:0]        Ram1_data,
    output logic               rdn,
    output logic               wrn,
    input  logic               data_ready,
    input  logic               tbre,
    input  logic               tsre
);

    state_e      state_q;
    target_e     target;
    logic        en_q, oe_q, we_q, rdn_q, wrn_q;
    logic        bus_oe_q;
    logic        ack_q;
    logic [17:0] addr_q;
    logic [15:0] wdat_q;
    logic [15:0] dout_q;
    logic        req;
    logic        is_wr;

    assign req   = bus.MemRead2 | bus.MemWrite2;
    // A simultaneous read+write request is treated as a write
    assign is_wr = bus.MemWrite2;

    ram1_addr_decode #(
        .UART_DATA_ADDR (UART_DATA_ADDR),
        .UART_STAT_ADDR (UART_STAT_ADDR)
    ) u_decode (
        .addr_i   (bus.Addr2),
        .target_o (target)
    );

    // Every strobe is driven straight from a flop so the pins cannot glitch.
    // Each state sets the strobe values for the phase it hands over to.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            en_q     <= 1'b1;
            oe_q     <= 1'b1;
            we_q     <= 1'b1;
            rdn_q    <= 1'b1;
            wrn_q    <= 1'b1;
            bus_oe_q <= 1'b0;
            ack_q    <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            dout_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q <= {2'b00, bus.Addr2};
                        wdat_q <= bus.DataIn2;
                        case (target)
                            TGT_SRAM: begin
                                en_q <= 1'b0;
                                if (is_wr) begin
                                    we_q     <= 1'b0;
                                    bus_oe_q <= 1'b1;
                                    state_q  <= SW1;
                                end else begin
                                    oe_q    <= 1'b0;
                                    state_q <= SR;
                                end
                            end
                            TGT_UDATA: begin
                                if (is_wr) begin
                                    wrn_q    <= 1'b0;
                                    bus_oe_q <= 1'b1;
                                    state_q  <= UW1;
                                end else begin
                                    rdn_q   <= 1'b0;
                                    state_q <= UR1;
                                end
                            end
                            default: begin
                                // Status register: reads return flags, writes are dropped
                                if (!is_wr) begin
                                    dout_q <= {14'b0, data_ready, tbre & tsre};
                                end
                                ack_q   <= 1'b1;
                                state_q <= ACK;
                            end
                        endcase
                    end
                end
                SR: begin
                    // Sample while OE is still low, then release the SRAM
                    dout_q  <= Ram1_data;
                    en_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    state_q <= SL;
                end
                SL: begin
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                SW1: begin
                    // WE rises here; bus stays driven one more cycle for hold time
                    we_q    <= 1'b1;
                    state_q <= SW2;
                end
                SW2: begin
                    en_q     <= 1'b1;
                    bus_oe_q <= 1'b0;
                    ack_q    <= 1'b1;
                    state_q  <= ACK;
                end
                UR1: begin
                    dout_q  <= Ram1_data;
                    rdn_q   <= 1'b1;
                    state_q <= UR2;
                end
                UR2: begin
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                UW1: begin
                    wrn_q   <= 1'b1;
                    state_q <= UW2;
                end
                UW2: begin
                    bus_oe_q <= 1'b0;
                    ack_q    <= 1'b1;
                    state_q  <= ACK;
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    en_q     <= 1'b1;
                    oe_q     <= 1'b1;
                    we_q     <= 1'b1;
                    rdn_q    <= 1'b1;
                    wrn_q    <= 1'b1;
                    bus_oe_q <= 1'b0;
                    ack_q    <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign Ram1_data    = bus_oe_q ? wdat_q : 16'hzzzz;
    assign Ram1_EN      = en_q;
    assign Ram1_OE      = oe_q;
    assign Ram1_WE      = we_q;
    assign rdn          = rdn_q;
    assign wrn          = wrn_q;
    assign Ram1_address = addr_q;
    assign bus.DataOut2 = dout_q;
    assign bus.Ack2     = ack_q;
    assign bus.Stall    = req & ~ack_q;

endmodule

// File: tb/tb_ram1_bus_ctrl.sv
// Directed bench for ram1_bus_ctrl: table of accesses plus a mid-access reset sequence.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram1_bus_ctrl;

    logic        Clk;
    logic        Rst;
    logic        Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn;
    logic [17:0] Ram1_address;
    wire  [15:0] ram1_data;
    logic        data_ready, tbre, tsre;
    logic [15:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    ram1_bus_ctrl_if bif ();

    ram1_bus_ctrl dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .bus          (bif),
        .Ram1_EN      (Ram1_EN),
        .Ram1_OE      (Ram1_OE),
        .Ram1_WE      (Ram1_WE),
        .Ram1_address (Ram1_address),
        .Ram1_data    (ram1_data),
        .rdn          (rdn),
        .wrn          (wrn),
        .data_ready   (data_ready),
        .tbre         (tbre),
        .tsre         (tsre)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model drives on EN&OE low; UART model drives 0x005A while rdn is low
    assign ram1_data = (!Ram1_EN && !Ram1_OE) ? mem[Ram1_address[7:0]] :
                       (!rdn ? 16'h005A : 16'hzzzz);

    always @(posedge Clk) begin
        if (!Ram1_EN && !Ram1_WE) mem[Ram1_address[7:0]] <= ram1_data;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        dr;
        logic        tb;
        logic        ts;
        logic [15:0] exp_dout;
        int          lat;
        int          we_lo;
        int          oe_lo;
        int          rdn_lo;
        int          wrn_lo;
        int          en_lo;
        int          drv;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic run_access(input vec_t v, input string tag);
        int we_c, oe_c, rdn_c, wrn_c, en_c, drv_c, stall_c, conflict_c, lat;
        logic [17:0] addr_seen;
        logic [15:0] wbus;
        bit acked;
        we_c = 0; oe_c = 0; rdn_c = 0; wrn_c = 0; en_c = 0; drv_c = 0;
        stall_c = 0; conflict_c = 0; lat = 0; acked = 0;
        addr_seen = '0; wbus = '0;
        @(posedge Clk); #1;
        chk({tag, "_idle_ack"}, int'(bif.Ack2), 0);
        bif.MemRead2  = v.rd;
        bif.MemWrite2 = v.wr;
        bif.Addr2     = v.addr;
        bif.DataIn2   = v.din;
        data_ready    = v.dr;
        tbre          = v.tb;
        tsre          = v.ts;
        #1;
        chk({tag, "_stall_req"}, int'(bif.Stall), 1);
        for (int c = 1; c <= 10 && !acked; c++) begin
            @(posedge Clk); #1;
            if (c == 1) addr_seen = Ram1_address;
            if (!Ram1_WE) we_c++;
            if (!Ram1_OE) oe_c++;
            if (!rdn) rdn_c++;
            if (!wrn) begin wrn_c++; wbus = ram1_data; end
            if (!Ram1_EN) en_c++;
            if (dut.bus_oe_q) drv_c++;
            if (bif.Stall) stall_c++;
            if (!Ram1_EN && (!rdn || !wrn)) conflict_c++;
            if (bif.Ack2) begin acked = 1; lat = c; end
        end
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_dout"}, int'(bif.DataOut2), int'(v.exp_dout));
        chk({tag, "_we_low"}, we_c, v.we_lo);
        chk({tag, "_oe_low"}, oe_c, v.oe_lo);
        chk({tag, "_rdn_low"}, rdn_c, v.rdn_lo);
        chk({tag, "_wrn_low"}, wrn_c, v.wrn_lo);
        chk({tag, "_en_low"}, en_c, v.en_lo);
        chk({tag, "_bus_drive"}, drv_c, v.drv);
        chk({tag, "_stall_cycles"}, stall_c, v.lat - 1);
        chk({tag, "_en_uart_overlap"}, conflict_c, 0);
        if (v.lat == 3) chk({tag, "_address"}, int'(addr_seen), int'({2'b00, v.addr}));
        if (v.wrn_lo > 0) chk({tag, "_uart_wdata"}, int'(wbus), int'(v.din));
        bif.MemRead2  = 1'b0;
        bif.MemWrite2 = 1'b0;
    endtask

    initial begin
        //            rd    wr    addr      din       dr    tb    ts    dout      lat we oe rd wr en drv
        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 1, 0, 0, 0, 2, 2};
        vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1234, 3, 0, 1, 0, 0, 1, 0};
        vecs[2] = '{1'b0, 1'b1, 16'hBF00, 16'h0041, 1'b0, 1'b0, 1'b0, 16'h1234, 3, 0, 0, 0, 1, 0, 2};
        vecs[3] = '{1'b1, 1'b0, 16'hBF00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h005A, 3, 0, 0, 1, 0, 0, 0};
        vecs[4] = '{1'b1, 1'b0, 16'hBF01, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 1, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0002, 3, 1, 0, 0, 0, 2, 2};
        vecs[6] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 3, 0, 1, 0, 0, 1, 0};
        vecs[7] = '{1'b0, 1'b1, 16'hBF01, 16'h7777, 1'b1, 1'b1, 1'b1, 16'hBEEF, 1, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{1'b1, 1'b0, 16'hBF01, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1, 0, 0, 0, 0, 0, 0};

        Rst = 1'b0;
        bif.MemRead2 = 1'b0; bif.MemWrite2 = 1'b0;
        bif.Addr2 = '0; bif.DataIn2 = '0;
        data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;

        #12;
        chk("rst_dout", int'(bif.DataOut2), 0);
        chk("rst_ack", int'(bif.Ack2), 0);
        chk("rst_stall", int'(bif.Stall), 0);
        chk("rst_strobes", int'({Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn}), 5'h1F);
        chk("rst_address", int'(Ram1_address), 0);
        chk("rst_bus_drive", int'(dut.bus_oe_q), 0);
        Rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset dropped in SW1 must abort the write immediately
        @(posedge Clk); #1;
        bif.MemWrite2 = 1'b1; bif.Addr2 = 16'h0030; bif.DataIn2 = 16'h5555;
        @(posedge Clk); #1;
        chk("midrst_in_sw1_we", int'(Ram1_WE), 0);
        Rst = 1'b0;
        #1;
        chk("midrst_we", int'(Ram1_WE), 1);
        chk("midrst_en", int'(Ram1_EN), 1);
        chk("midrst_bus_drive", int'(dut.bus_oe_q), 0);
        chk("midrst_ack", int'(bif.Ack2), 0);
        bif.MemWrite2 = 1'b0;
        @(posedge Clk); #2;
        Rst = 1'b1;
        run_access(vecs[1], "post_rst_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard ceiling so the run always terminates
    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
